// File: rtl/sparse_mac_array.sv
// Sparse MAC array: per-channel act-block select, 2-stage multiply-accumulate.
// Optional ACC_SAT_EN: saturating accumulate plus sticky per-channel out_sat.
module sparse_mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                             Clk,
  input  logic                                             Rst,
  input  logic                                             act_load,
  input  logic [ARRAY_SIZE*BLOCK_SIZE*BLOCK_SIZE*DATA_WIDTH-1:0] Input_act,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]                  Resultln,
  input  logic                                             start,
  input  logic [LEN_WIDTH-1:0]                             nnz_len,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]                 Input_weight,
  input  logic [ARRAY_SIZE*SEL_WIDTH-1:0]                  mask,
  input  logic [ARRAY_SIZE-1:0]                            mask_zero,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]                  Array_Output,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             busy
`ifdef ACC_SAT_EN
  ,
  output logic [ARRAY_SIZE-1:0]                            out_sat
`endif
);

  localparam int NE = BLOCK_SIZE * BLOCK_SIZE;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                        state_q;
  logic [LEN_WIDTH-1:0]          cnt_q;
  logic                          prod_vld_q;
  logic [DATA_WIDTH-1:0]         act_q   [ARRAY_SIZE][NE];
  logic signed [PW-1:0]          prod_q  [ARRAY_SIZE];
  logic signed [PW-1:0]          prod_d  [ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc_q   [ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc_d   [ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0]   pext    [ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0]  a_sel   [ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0]  w_sel   [ARRAY_SIZE];
  logic [ARRAY_SIZE*ACC_WIDTH-1:0] out_q;
  logic                          hs;

`ifdef ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] MAXV = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MINV = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0]            sum_w   [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]         clip_d;
  logic [ARRAY_SIZE-1:0]         sat_q;
  assign out_sat = sat_q;
`endif

  assign in_ready     = (state_q == S_ACCUM);
  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign Array_Output = out_q;
  assign hs           = in_valid && in_ready;

  always_comb begin
`ifdef ACC_SAT_EN
    clip_d = '0;
`endif
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      a_sel[c] = act_q[c][mask[c*SEL_WIDTH +: SEL_WIDTH]];
      w_sel[c] = Input_weight[c*DATA_WIDTH +: DATA_WIDTH];
      if (mask_zero[c]) prod_d[c] = '0;
      else              prod_d[c] = a_sel[c] * w_sel[c];
      pext[c] = ACC_WIDTH'(prod_q[c]);
`ifdef ACC_SAT_EN
      sum_w[c] = {acc_q[c][ACC_WIDTH-1], acc_q[c]}
               + {pext[c][ACC_WIDTH-1], pext[c]};
      acc_d[c] = acc_q[c];
      if (prod_vld_q) begin
        // Overflow shows up as the two top bits disagreeing.
        if (sum_w[c][ACC_WIDTH] != sum_w[c][ACC_WIDTH-1]) begin
          clip_d[c] = 1'b1;
          acc_d[c]  = sum_w[c][ACC_WIDTH] ? MINV : MAXV;
        end else begin
          acc_d[c]  = sum_w[c][ACC_WIDTH-1:0];
        end
      end
`else
      acc_d[c] = prod_vld_q ? acc_q[c] + pext[c] : acc_q[c];
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
      out_q      <= '0;
`ifdef ACC_SAT_EN
      sat_q      <= '0;
`endif
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        acc_q[c]  <= '0;
        prod_q[c] <= '0;
        for (int k = 0; k < NE; k++) act_q[c][k] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          prod_vld_q <= 1'b0;
          if (act_load) begin
            for (int c = 0; c < ARRAY_SIZE; c++)
              for (int k = 0; k < NE; k++)
                act_q[c][k] <= Input_act[(c*NE+k)*DATA_WIDTH +: DATA_WIDTH];
          end
          if (start) begin
            cnt_q <= nnz_len;
`ifdef ACC_SAT_EN
            sat_q <= '0;
`endif
            for (int c = 0; c < ARRAY_SIZE; c++)
              acc_q[c] <= Resultln[c*ACC_WIDTH +: ACC_WIDTH];
            if (nnz_len == '0) begin
              out_q   <= Resultln;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          prod_vld_q <= hs;
`ifdef ACC_SAT_EN
          sat_q <= sat_q | clip_d;
`endif
          for (int c = 0; c < ARRAY_SIZE; c++) begin
            acc_q[c] <= acc_d[c];
            if (hs) prod_q[c] <= prod_d[c];
          end
          if (hs) begin
            cnt_q <= cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          prod_vld_q <= 1'b0;
`ifdef ACC_SAT_EN
          sat_q <= sat_q | clip_d;
`endif
          for (int c = 0; c < ARRAY_SIZE; c++) begin
            acc_q[c] <= acc_d[c];
            out_q[c*ACC_WIDTH +: ACC_WIDTH] <= acc_d[c];
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_mac_array.sv
// Scoreboard bench for sparse_mac_array: random passes vs. arithmetic model.
// Directed cases cover zero length, back-pressure, reset abort and wrap.
module tb_sparse_mac_array;
  localparam int DW = 8;
  localparam int BS = 4;
  localparam int AS = 4;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int LW = 8;
  localparam int NE = BS * BS;
  localparam int MB = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic act_load, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [AS*NE*DW-1:0] Input_act;
  logic [AS*AW-1:0]    Resultln, Array_Output;
  logic [LW-1:0]       nnz_len;
  logic [AS*DW-1:0]    Input_weight;
  logic [AS*SW-1:0]    mask;
  logic [AS-1:0]       mask_zero;
`ifdef ACC_SAT_EN
  logic [AS-1:0]       out_sat;
`endif

  always #5 clk = ~clk;

  sparse_mac_array dut (
    .Clk(clk), .Rst(rst_n), .act_load(act_load), .Input_act(Input_act),
    .Resultln(Resultln), .start(start), .nnz_len(nnz_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .Input_weight(Input_weight), .mask(mask), .mask_zero(mask_zero),
    .Array_Output(Array_Output), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
`ifdef ACC_SAT_EN
    , .out_sat(out_sat)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [AS*AW-1:0] exp_q[$];

  logic signed [DW-1:0] m_act [AS][NE];
  logic signed [AW-1:0] bias  [AS];
  logic signed [DW-1:0] bw    [AS][MB];
  int                   bm    [AS][MB];
  bit                   bz    [AS][MB];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AS*AW-1:0] model(int n);
    logic [AS*AW-1:0] r;
    logic signed [AW-1:0] a;
    longint t;
    longint maxl;
    longint minl;
    maxl = (longint'(1) <<< (AW-1)) - 1;
    minl = -(longint'(1) <<< (AW-1));
    r = '0;
    for (int c = 0; c < AS; c++) begin
      a = bias[c];
      for (int b = 0; b < n; b++) begin
        if (!bz[c][b]) begin
          t = longint'(a) + longint'(m_act[c][bm[c][b]]) * longint'(bw[c][b]);
`ifdef ACC_SAT_EN
          if (t > maxl)      a = AW'(maxl);
          else if (t < minl) a = AW'(minl);
          else               a = t[AW-1:0];
`else
          a = t[AW-1:0];
`endif
        end
      end
      r[c*AW +: AW] = a;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_act();
    for (int c = 0; c < AS; c++)
      for (int k = 0; k < NE; k++)
        Input_act[(c*NE+k)*DW +: DW] = m_act[c][k];
  endtask

  task automatic load_act();
    pack_act();
    act_load = 1'b1;
    tick();
    act_load = 1'b0;
  endtask

  task automatic drive_beat(int b);
    for (int c = 0; c < AS; c++) begin
      Input_weight[c*DW +: DW] = bw[c][b];
      mask[c*SW +: SW]         = SW'(bm[c][b]);
      mask_zero[c]             = bz[c][b];
    end
  endtask

  task automatic check_reset(string nm);
    chk({nm, "_out"},    Array_Output, '0);
    chk({nm, "_valid"},  out_valid, 0);
    chk({nm, "_inrdy"},  in_ready, 0);
    chk({nm, "_busy"},   busy, 0);
  endtask

  // ordly > 0: out_ready held low for ordly DONE cycles while start/act_load pulse
  task automatic run_pass(int n, int gap, int ordly, int abort_at);
    logic [AS*AW-1:0] snap;
    int to;
    if (abort_at < 0) exp_q.push_back(model(n));
    out_ready = (ordly == 0);
    for (int c = 0; c < AS; c++) Resultln[c*AW +: AW] = bias[c];
    nnz_len = LW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zlen_valid", out_valid, 1);
      chk("zlen_inrdy", in_ready, 0);
    end
    for (int b = 0; b < n; b++) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset("abort");
        return;
      end
      in_valid = 1'b0;
      repeat (gap) tick();
      drive_beat(b);
      in_valid = 1'b1;
      to = 0;
      while (!in_ready && to < 50) begin
        tick();
        to++;
      end
      if (to >= 50) chk("beat_timeout", 1, 0);
      tick();
      in_valid = 1'b0;
    end
    if (n > 0) begin
      chk("flush_inrdy", in_ready, 0);
      chk("lat_early", out_valid, 0);
      tick();
      chk("lat_valid", out_valid, 1);
    end
    if (ordly > 0) begin
      snap = Array_Output;
      for (int i = 0; i < ordly; i++) begin
        start    = 1'b1;
        act_load = 1'b1;
        in_valid = 1'b1;
        nnz_len  = 8'd3;
        Input_act = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("hold_valid", out_valid, 1);
        chk("hold_out", Array_Output, snap);
        chk("hold_inrdy", in_ready, 0);
      end
      start    = 1'b0;
      act_load = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("release_busy", busy, 0);
    end
    to = 0;
    while (busy && to < 50) begin
      tick();
      to++;
    end
    chk("pass_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    logic [AS*AW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int c = 0; c < AS; c++)
          chk($sformatf("result_ch%0d", c),
              Array_Output[c*AW +: AW], e[c*AW +: AW]);
      end
    end
  end

  task automatic rand_beats(int n);
    for (int c = 0; c < AS; c++)
      for (int b = 0; b < n; b++) begin
        bw[c][b] = DW'($urandom);
        bm[c][b] = int'($urandom_range(0, NE-1));
        bz[c][b] = ($urandom_range(0, 3) == 0);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    act_load = 0; start = 0; in_valid = 0; out_ready = 1;
    Input_act = '0; Resultln = '0; nnz_len = '0;
    Input_weight = '0; mask = '0; mask_zero = '0;
    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;

    for (int c = 0; c < AS; c++) begin
      for (int k = 0; k < NE; k++) m_act[c][k] = DW'(k);
      m_act[c][0] = 8'sd16;
      bias[c] = AW'(200 + 10*c);
      for (int b = 0; b < 4; b++) begin
        bw[c][b] = 8'sd1; bm[c][b] = b; bz[c][b] = 1'b0;
      end
    end
    load_act();
    run_pass(4, 0, 0, -1);
    chk("tp1_ch0", Array_Output[31:0], 222);
    chk("tp1_ch3", Array_Output[127:96], 252);

    run_pass(0, 0, 0, -1);
    chk("tp2_ch1", Array_Output[63:32], 210);

    for (int c = 0; c < AS; c++)
      for (int b = 0; b < 2; b++) begin
        bw[c][b] = -8'sd1; bm[c][b] = 15; bz[c][b] = (c == 2);
      end
    run_pass(2, 0, 0, -1);
    chk("tp3_ch0", Array_Output[31:0], 170);
    run_pass(2, 3, 0, -1);
    chk("tp3_ch2", Array_Output[95:64], 220);
    chk("tp3_ch3", Array_Output[127:96], 200);

    run_pass(2, 1, 5, -1);
    run_pass(2, 0, 0, -1);
    chk("tp4_ch1", Array_Output[63:32], 180);

    rand_beats(4);
    run_pass(4, 0, 0, 2);
    for (int c = 0; c < AS; c++)
      for (int k = 0; k < NE; k++) m_act[c][k] = '0;
    rand_beats(3);
    run_pass(3, 0, 0, -1);
    for (int c = 0; c < AS; c++)
      for (int k = 0; k < NE; k++) m_act[c][k] = DW'($urandom);
    load_act();
    run_pass(4, 1, 0, -1);

    bias[0] = 32'h7FFF_FFFF;
    m_act[0][1] = 8'sd1;
    for (int c = 0; c < AS; c++) begin
      bw[c][0] = 8'sd1; bm[c][0] = 1; bz[c][0] = (c != 0);
    end
    load_act();
    run_pass(1, 0, 0, -1);
`ifdef ACC_SAT_EN
    chk("wrap_ch0", Array_Output[31:0], 32'h7FFF_FFFF);
    chk("sat_ch0", out_sat[0], 1);
`else
    chk("wrap_ch0", Array_Output[31:0], 32'h8000_0000);
`endif

    for (int p = 0; p < 25; p++) begin
      int n;
      n = int'($urandom_range(0, 10));
      for (int c = 0; c < AS; c++)
        bias[c] = AW'(int'($urandom_range(0, 2000)) - 1000);
      if ($urandom_range(0, 1) == 1) begin
        for (int c = 0; c < AS; c++)
          for (int k = 0; k < NE; k++) m_act[c][k] = DW'($urandom);
        load_act();
      end
      rand_beats(n);
      run_pass(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
